retire_stage: RTL and testbench

- Commit stage directly downstream of the ROB. Consumes the two head ROB packets and their retire-ready flags.
- Per retired instruction: commits architectural rename state, returns the old physical register to the free list, and releases stores to the SQ.
- Detects branch mispredicts and load-ordering violations at retire. Issues a one-cycle pipeline squash with a redirect PC, then holds a short recovery window.
- Latches halt/illegal and stops retirement.

---
 rtl/sys_defs_pkg.sv | 49 ++++
 rtl/retire_stage_event_detect.sv | 39 +++
 rtl/retire_stage.sv | 194 +++++++++++++++++++
 tb/tb_retire_stage.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs_pkg.sv
// Shared retire-stage types: ROB head packet, retire bundle, FSM and event enums.
package sys_defs;

  localparam int XLEN      = 32;
  localparam int PRF_SIZE  = 64;
  localparam int PRF_IDX_W = $clog2(PRF_SIZE);
  localparam int ARF_SIZE  = 32;
  localparam int ARF_IDX_W = 5;
  localparam int CNT_W     = 4;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      pc;
    logic [31:0]          inst;
    logic [PRF_IDX_W-1:0] T_new;
    logic [PRF_IDX_W-1:0] T_old;
    logic                 wr_mem;
    logic                 halt;
    logic                 illegal;
    logic                 rd_mem_violation;
    logic                 is_branch;
    logic                 predict_take_branch;
    logic [XLEN-1:0]      predict_target_pc;
    logic                 ex_take_branch;
    logic [XLEN-1:0]      ex_target_pc;
  } ROB_PACKET;

  typedef struct packed {
    logic                 valid;
    logic [ARF_IDX_W-1:0] arch_idx;
    logic [PRF_IDX_W-1:0] T_new;
    logic [PRF_IDX_W-1:0] T_old;
    logic                 store;
  } RETIRE_PACKET;

  typedef enum logic [1:0] {
    RUN,
    RECOVER,
    HALTED
  } RETIRE_STATE;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_HALT,
    EV_VIOL,
    EV_BRANCH
  } EVENT_KIND;

endpackage

// File: rtl/retire_stage_event_detect.sv
// Per-slot retire event classifier: halt/illegal > ordering violation > mispredict.
module retire_event_detect
  import sys_defs::*;
(
  input  ROB_PACKET       pkt,
  output logic            is_event,
  output EVENT_KIND       event_kind,
  output logic [XLEN-1:0] target
);

  logic mispred;
  logic unused_fields;

  assign unused_fields = ^{pkt.valid, pkt.inst, pkt.T_new,
                           pkt.T_old, pkt.wr_mem};

  assign mispred = pkt.is_branch &&
    ((pkt.ex_take_branch != pkt.predict_take_branch) ||
     (pkt.ex_take_branch &&
      (pkt.ex_target_pc != pkt.predict_target_pc)));

  always_comb begin
    event_kind = EV_NONE;
    target     = '0;
    if (pkt.halt || pkt.illegal) begin
      event_kind = EV_HALT;
    end else if (pkt.rd_mem_violation) begin
      event_kind = EV_VIOL;
      target     = pkt.pc;
    end else if (mispred) begin
      event_kind = EV_BRANCH;
      target     = pkt.ex_take_branch ? pkt.ex_target_pc
                                      : pkt.pc + 32'd4;
    end
  end

  assign is_event = (event_kind != EV_NONE);

endmodule

// File: rtl/retire_stage.sv
// Two-wide commit stage with squash/recovery FSM and sticky halt.
// Optional RETIRE_STATS_EN adds saturating retire/mispredict counters.
module retire_stage
  import sys_defs::*;
#(
  parameter int RECOVERY_CYCLES = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  ROB_PACKET [1:0]           rob_packet_in,
  input  logic                      head_retire_rdy,
  input  logic                      head_p1_retire_rdy,
  output logic [1:0]                retire_valid,
  output logic [1:0][ARF_IDX_W-1:0] retire_arch_idx,
  output logic [1:0][PRF_IDX_W-1:0] retire_T_new,
  output logic [1:0][PRF_IDX_W-1:0] retire_T_old,
  output logic [1:0]                retire_store,
  output logic                      squash,
  output logic [XLEN-1:0]           redirect_pc,
  output logic                      retire_block,
  output logic                      halted,
  output logic                      illegal_halt
`ifdef RETIRE_STATS_EN
  ,
  output logic [63:0]               retired_cnt,
  output logic [31:0]               mispredict_cnt
`endif
);

  RETIRE_STATE        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  RETIRE_PACKET [1:0] ret_q, ret_d;
  logic               squash_q, squash_d;
  logic [XLEN-1:0]    redir_q, redir_d;
  logic               block_q, block_d;
  logic               halted_q, halted_d;
  logic               ill_q, ill_d;

  logic             ev0, ev1, el0, el1, sel1;
  EVENT_KIND        kind0, kind1, act_kind;
  logic [XLEN-1:0]  tgt0, tgt1, act_tgt;
  logic             act_ill;

  retire_event_detect u_det0 (
    .pkt        (rob_packet_in[0]),
    .is_event   (ev0),
    .event_kind (kind0),
    .target     (tgt0)
  );

  retire_event_detect u_det1 (
    .pkt        (rob_packet_in[1]),
    .is_event   (ev1),
    .event_kind (kind1),
    .target     (tgt1)
  );

  assign el0 = head_retire_rdy && rob_packet_in[0].valid &&
               (state_q == RUN);
  assign el1 = el0 && head_p1_retire_rdy &&
               rob_packet_in[1].valid && !ev0;

  // Slot0 event wins; slot1 is only eligible when slot0 is clean.
  assign sel1     = !(el0 && ev0);
  assign act_kind = (el0 && ev0) ? kind0 :
                    (el1 && ev1) ? kind1 : EV_NONE;
  assign act_tgt  = sel1 ? tgt1 : tgt0;
  assign act_ill  = sel1 ? rob_packet_in[1].illegal
                         : rob_packet_in[0].illegal;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (act_kind == EV_HALT) begin
          state_d = HALTED;
        end else if (act_kind == EV_VIOL ||
                     act_kind == EV_BRANCH) begin
          state_d = RECOVER;
          cnt_d   = CNT_W'(RECOVERY_CYCLES);
        end
      end
      RECOVER: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ret_d[i] = '0;
    end
    if (el0) begin
      ret_d[0].valid    = 1'b1;
      ret_d[0].arch_idx = rob_packet_in[0].inst[11:7];
      ret_d[0].T_new    = rob_packet_in[0].T_new;
      ret_d[0].T_old    = rob_packet_in[0].T_old;
      ret_d[0].store    = rob_packet_in[0].wr_mem;
    end
    if (el1) begin
      ret_d[1].valid    = 1'b1;
      ret_d[1].arch_idx = rob_packet_in[1].inst[11:7];
      ret_d[1].T_new    = rob_packet_in[1].T_new;
      ret_d[1].T_old    = rob_packet_in[1].T_old;
      ret_d[1].store    = rob_packet_in[1].wr_mem;
    end
    squash_d = (act_kind == EV_VIOL) || (act_kind == EV_BRANCH);
    redir_d  = squash_d ? act_tgt : '0;
    block_d  = (state_d != RUN);
    halted_d = halted_q || (act_kind == EV_HALT);
    ill_d    = ill_q || ((act_kind == EV_HALT) && act_ill);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ret_q    <= '0;
      squash_q <= 1'b0;
      redir_q  <= '0;
      block_q  <= 1'b0;
      halted_q <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      ret_q    <= ret_d;
      squash_q <= squash_d;
      redir_q  <= redir_d;
      block_q  <= block_d;
      halted_q <= halted_d;
      ill_q    <= ill_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      retire_valid[i]    = ret_q[i].valid;
      retire_arch_idx[i] = ret_q[i].arch_idx;
      retire_T_new[i]    = ret_q[i].T_new;
      retire_T_old[i]    = ret_q[i].T_old;
      retire_store[i]    = ret_q[i].store;
    end
  end

  assign squash       = squash_q;
  assign redirect_pc  = redir_q;
  assign retire_block = block_q;
  assign halted       = halted_q;
  assign illegal_halt = ill_q;

`ifdef RETIRE_STATS_EN
  logic [63:0] rcnt_q, rcnt_d;
  logic [31:0] mcnt_q, mcnt_d;
  logic [1:0]  inc;

  always_comb begin
    inc = {1'b0, ret_d[0].valid} + {1'b0, ret_d[1].valid};
    if (rcnt_q > ('1 - {62'd0, inc})) rcnt_d = '1;
    else                              rcnt_d = rcnt_q + {62'd0, inc};
    mcnt_d = mcnt_q;
    if (act_kind == EV_BRANCH && mcnt_q != '1)
      mcnt_d = mcnt_q + 32'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      rcnt_q <= rcnt_d;
      mcnt_q <= mcnt_d;
    end
  end

  assign retired_cnt    = rcnt_q;
  assign mispredict_cnt = mcnt_q;
`endif

endmodule

// File: tb/tb_retire_stage.sv
// Scoreboard bench for retire_stage: expected outputs queued per cycle.
module tb_retire_stage;
  import sys_defs::*;

  logic                      clock;
  logic                      reset;
  ROB_PACKET [1:0]           rob_packet_in;
  logic                      head_retire_rdy;
  logic                      head_p1_retire_rdy;
  logic [1:0]                retire_valid;
  logic [1:0][ARF_IDX_W-1:0] retire_arch_idx;
  logic [1:0][PRF_IDX_W-1:0] retire_T_new;
  logic [1:0][PRF_IDX_W-1:0] retire_T_old;
  logic [1:0]                retire_store;
  logic                      squash;
  logic [XLEN-1:0]           redirect_pc;
  logic                      retire_block;
  logic                      halted;
  logic                      illegal_halt;
`ifdef RETIRE_STATS_EN
  logic [63:0]               retired_cnt;
  logic [31:0]               mispredict_cnt;
`endif

  retire_stage dut (
    .clock              (clock),
    .reset              (reset),
    .rob_packet_in      (rob_packet_in),
    .head_retire_rdy    (head_retire_rdy),
    .head_p1_retire_rdy (head_p1_retire_rdy),
    .retire_valid       (retire_valid),
    .retire_arch_idx    (retire_arch_idx),
    .retire_T_new       (retire_T_new),
    .retire_T_old       (retire_T_old),
    .retire_store       (retire_store),
    .squash             (squash),
    .redirect_pc        (redirect_pc),
    .retire_block       (retire_block),
    .halted             (halted),
    .illegal_halt       (illegal_halt)
`ifdef RETIRE_STATS_EN
    ,
    .retired_cnt        (retired_cnt),
    .mispredict_cnt     (mispredict_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  v;
    logic [9:0]  arch;
    logic [11:0] tn;
    logic [11:0] to;
    logic [1:0]  st;
    logic        sq;
    logic [31:0] pc;
    logic        blk;
    logic        hlt;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic ROB_PACKET alu(input logic [31:0] pc,
                                    input logic [4:0] rd,
                                    input logic [5:0] tn,
                                    input logic [5:0] to);
    ROB_PACKET p;
    p       = '0;
    p.valid = 1'b1;
    p.pc    = pc;
    p.inst  = {20'd0, rd, 7'b0110011};
    p.T_new = tn;
    p.T_old = to;
    return p;
  endfunction

  function automatic exp_t ex(input logic [1:0] v,
                              input logic [9:0] arch,
                              input logic [11:0] tn,
                              input logic [11:0] to,
                              input logic [1:0] st,
                              input logic sq,
                              input logic [31:0] pc,
                              input logic blk,
                              input logic hlt,
                              input logic ill);
    exp_t e;
    e.v = v; e.arch = arch; e.tn = tn; e.to = to; e.st = st;
    e.sq = sq; e.pc = pc; e.blk = blk; e.hlt = hlt; e.ill = ill;
    return e;
  endfunction

  task automatic step(input string tag, input exp_t e);
    exp_t got;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    got = sb_q.pop_front();
    chk({tag, ".valid"}, 64'(retire_valid), 64'(got.v));
    chk({tag, ".arch"}, 64'(retire_arch_idx), 64'(got.arch));
    chk({tag, ".tnew"}, 64'(retire_T_new), 64'(got.tn));
    chk({tag, ".told"}, 64'(retire_T_old), 64'(got.to));
    chk({tag, ".store"}, 64'(retire_store), 64'(got.st));
    chk({tag, ".squash"}, 64'(squash), 64'(got.sq));
    chk({tag, ".redir"}, 64'(redirect_pc), 64'(got.pc));
    chk({tag, ".block"}, 64'(retire_block), 64'(got.blk));
    chk({tag, ".halted"}, 64'(halted), 64'(got.hlt));
    chk({tag, ".ill"}, 64'(illegal_halt), 64'(got.ill));
    @(negedge clock);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, 64'(retire_valid), 64'd0);
    chk({tag, ".arch"}, 64'(retire_arch_idx), 64'd0);
    chk({tag, ".tnew"}, 64'(retire_T_new), 64'd0);
    chk({tag, ".told"}, 64'(retire_T_old), 64'd0);
    chk({tag, ".store"}, 64'(retire_store), 64'd0);
    chk({tag, ".squash"}, 64'(squash), 64'd0);
    chk({tag, ".redir"}, 64'(redirect_pc), 64'd0);
    chk({tag, ".block"}, 64'(retire_block), 64'd0);
    chk({tag, ".halted"}, 64'(halted), 64'd0);
    chk({tag, ".ill"}, 64'(illegal_halt), 64'd0);
  endtask

  task automatic set_in(input ROB_PACKET p0, input ROB_PACKET p1,
                        input logic r0, input logic r1);
    rob_packet_in[0]   = p0;
    rob_packet_in[1]   = p1;
    head_retire_rdy    = r0;
    head_p1_retire_rdy = r1;
  endtask

  exp_t idle_blk, idle, both;
  ROB_PACKET a0, a1, p;

  initial begin
    reset = 1'b0;
    set_in('0, '0, 1'b0, 1'b0);
    idle_blk = ex(2'b00, 10'd0, 12'd0, 12'd0, 2'b00, 1'b0, 32'd0,
                  1'b1, 1'b0, 1'b0);
    idle     = ex(2'b00, 10'd0, 12'd0, 12'd0, 2'b00, 1'b0, 32'd0,
                  1'b0, 1'b0, 1'b0);
    both     = ex(2'b11, {5'd6, 5'd5}, {6'd41, 6'd40}, {6'd13, 6'd12},
                  2'b00, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    #3;
    chk_zero("rst");
    @(negedge clock);
    reset = 1'b1;

    a0 = alu(32'h100, 5'd5, 6'd40, 6'd12);
    a1 = alu(32'h104, 5'd6, 6'd41, 6'd13);
    set_in(a0, a1, 1'b1, 1'b1);
    step("alu2", both);

    p = alu(32'h108, 5'd0, 6'd0, 6'd0);
    p.is_branch = 1'b1;
    p.ex_take_branch = 1'b1;
    p.ex_target_pc = 32'h200;
    set_in(p, a1, 1'b1, 1'b1);
    step("br", ex(2'b01, 10'd0, 12'd0, 12'd0, 2'b00, 1'b1, 32'h200,
                  1'b1, 1'b0, 1'b0));
    set_in(a0, a1, 1'b1, 1'b1);
    step("br.rec1", idle_blk);
    step("br.rec2", idle);
    step("br.resume", both);

    p = alu(32'h104, 5'd7, 6'd42, 6'd14);
    p.rd_mem_violation = 1'b1;
    set_in(p, a1, 1'b1, 1'b1);
    step("viol", ex(2'b01, {5'd0, 5'd7}, {6'd0, 6'd42}, {6'd0, 6'd14},
                    2'b00, 1'b1, 32'h104, 1'b1, 1'b0, 1'b0));
    set_in('0, '0, 1'b0, 1'b0);
    step("viol.rec1", idle_blk);
    step("viol.rec2", idle);

    p = alu(32'h110, 5'd0, 6'd0, 6'd0);
    p.wr_mem = 1'b1;
    set_in(p, a1, 1'b1, 1'b0);
    step("store", ex(2'b01, 10'd0, 12'd0, 12'd0, 2'b01, 1'b0, 32'd0,
                     1'b0, 1'b0, 1'b0));

    p = alu(32'h120, 5'd0, 6'd0, 6'd0);
    p.is_branch = 1'b1;
    p.predict_take_branch = 1'b1;
    p.predict_target_pc = 32'h180;
    p.ex_take_branch = 1'b1;
    p.ex_target_pc = 32'h180;
    set_in(p, alu(32'h180, 5'd6, 6'd41, 6'd13), 1'b1, 1'b1);
    step("br.ok", ex(2'b11, {5'd6, 5'd0}, {6'd41, 6'd0},
                     {6'd13, 6'd0}, 2'b00, 1'b0, 32'd0,
                     1'b0, 1'b0, 1'b0));

    p = alu(32'h300, 5'd0, 6'd0, 6'd0);
    p.is_branch = 1'b1;
    p.predict_take_branch = 1'b1;
    p.predict_target_pc = 32'h400;
    p.ex_target_pc = 32'h400;
    set_in(p, a1, 1'b1, 1'b1);
    step("br.nt", ex(2'b01, 10'd0, 12'd0, 12'd0, 2'b00, 1'b1, 32'h304,
                     1'b1, 1'b0, 1'b0));
    set_in('0, '0, 1'b0, 1'b0);
    step("br.nt.rec1", idle_blk);
    step("br.nt.rec2", idle);

    p = alu(32'h504, 5'd0, 6'd0, 6'd0);
    p.is_branch = 1'b1;
    p.predict_take_branch = 1'b1;
    p.predict_target_pc = 32'h600;
    p.ex_take_branch = 1'b1;
    p.ex_target_pc = 32'h640;
    set_in(alu(32'h500, 5'd5, 6'd40, 6'd12), p, 1'b1, 1'b1);
    step("br.s1", ex(2'b11, {5'd0, 5'd5}, {6'd0, 6'd40},
                     {6'd0, 6'd12}, 2'b00, 1'b1, 32'h640,
                     1'b1, 1'b0, 1'b0));
    set_in('0, '0, 1'b0, 1'b0);
    step("br.s1.rec1", idle_blk);
    step("br.s1.rec2", idle);

    p = alu(32'h700, 5'd7, 6'd42, 6'd14);
    p.rd_mem_violation = 1'b1;
    a1 = alu(32'h704, 5'd0, 6'd0, 6'd0);
    a1.halt = 1'b1;
    set_in(p, a1, 1'b1, 1'b1);
    step("dual", ex(2'b01, {5'd0, 5'd7}, {6'd0, 6'd42},
                    {6'd0, 6'd14}, 2'b00, 1'b1, 32'h700,
                    1'b1, 1'b0, 1'b0));
    set_in('0, '0, 1'b0, 1'b0);
    step("dual.rec1", idle_blk);
    step("dual.rec2", idle);

    set_in(alu(32'h800, 5'd5, 6'd40, 6'd12), a1, 1'b1, 1'b1);
    step("halt", ex(2'b11, {5'd0, 5'd5}, {6'd0, 6'd40},
                    {6'd0, 6'd12}, 2'b00, 1'b0, 32'd0,
                    1'b1, 1'b1, 1'b0));
    a1 = alu(32'h104, 5'd6, 6'd41, 6'd13);
    set_in(a0, a1, 1'b1, 1'b1);
    step("halt.hold1", ex(2'b00, 10'd0, 12'd0, 12'd0, 2'b00, 1'b0,
                          32'd0, 1'b1, 1'b1, 1'b0));
    step("halt.hold2", ex(2'b00, 10'd0, 12'd0, 12'd0, 2'b00, 1'b0,
                          32'd0, 1'b1, 1'b1, 1'b0));
    reset = 1'b0;
    #1;
    chk_zero("rst.halted");
    @(negedge clock);
    reset = 1'b1;

    p = alu(32'h900, 5'd0, 6'd0, 6'd0);
    p.illegal = 1'b1;
    set_in(p, a1, 1'b1, 1'b1);
    step("illegal", ex(2'b01, 10'd0, 12'd0, 12'd0, 2'b00, 1'b0,
                       32'd0, 1'b1, 1'b1, 1'b1));
    reset = 1'b0;
    #1;
    chk_zero("rst.illegal");
    @(negedge clock);
    reset = 1'b1;

    p = alu(32'hA00, 5'd0, 6'd0, 6'd0);
    p.is_branch = 1'b1;
    p.ex_take_branch = 1'b1;
    p.ex_target_pc = 32'hB00;
    set_in(p, a1, 1'b1, 1'b1);
    step("br2", ex(2'b01, 10'd0, 12'd0, 12'd0, 2'b00, 1'b1, 32'hB00,
                   1'b1, 1'b0, 1'b0));
    set_in('0, '0, 1'b0, 1'b0);
    step("br2.rec1", idle_blk);
    reset = 1'b0;
    #1;
    chk_zero("rst.recover");
    @(negedge clock);
    reset = 1'b1;
    set_in(a0, a1, 1'b1, 1'b0);
    step("post.rst", ex(2'b01, {5'd0, 5'd5}, {6'd0, 6'd40},
                        {6'd0, 6'd12}, 2'b00, 1'b0, 32'd0,
                        1'b0, 1'b0, 1'b0));
    set_in('0, '0, 1'b0, 1'b0);
    step("idle.end", idle);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
